sid_env_ctrl: RTL and testbench
===============================

// Module: sid_env_ctrl
// PURPOSE
// Register front end and scheduler for the per-voice ADSR envelope generators.
// Decodes SID-style bus writes into staged per-voice ADSR and gate settings, generates the
// shared envelope clock enable, and commits staged settings one cycle before each enable so
// every envelope sees coherent, stable inputs. Stretches short gate pulses so none is lost
// between ticks, and returns voice-3 envelope level on ENV3 reads.
// PARAMETERS
// CLK_DIV     32  system clocks per envelope tick; legal range 2..65535
// NUM_VOICES  3   voices served; register map supports up to 3
// PORTS
// clk          in   1             system clock
// n_reset      in   1             synchronous, active-low reset
// cs           in   1             bus access request
// we           in   1             1 = write, 0 = read; qualified by cs
// addr         in   5             SID register address
// wdata        in   8             write data
// rdata        out  8             read data; valid while ready=1
// ready        out  1             one-cycle access-complete pulse
// env_clk_en   out  1             one-cycle tick; drives clk_en of every envelope
// env_atk      out  NUM_VOICES*4  committed attack rate per voice
// env_dcy      out  NUM_VOICES*4  committed decay rate per voice
// env_stn      out  NUM_VOICES*4  committed sustain level per voice
// env_rls      out  NUM_VOICES*4  committed release rate per voice
// env_gate     out  NUM_VOICES    committed gate per voice
// env_vol      in   NUM_VOICES*8  envelope level from each voice
// BEHAVIOUR
// - Reset (n_reset=0 at posedge): all staged/committed fields, gate_pend, divider, rdata,
//   ready, env_clk_en <= 0. Reset wins over any same-cycle access or tick.
// - Divider: cnt counts 0..CLK_DIV-1 and wraps. commit strobe when cnt==CLK_DIV-2.
//   env_clk_en is registered high for the cycle with cnt==CLK_DIV-1. First tick is in cycle
//   CLK_DIV after reset release. Period is exactly CLK_DIV.
// - Register map, voice v at base 7*v:
//   +4 CTRL[0] = gate.
//   +5 AD = {atk,dcy}.
//   +6 SR = {stn,rls}.
//   0x1C ENV3 = env_vol of voice 2, read-only.
//   Other addresses: writes ignored, reads return 0. CTRL/AD/SR are write-only; reads return 0.
// - Bus FSM IDLE -> RESP -> IDLE:
//   - Accept in IDLE when cs=1; write updates staged regs at that edge, read registers rdata.
//   - RESP: ready=1 for exactly one cycle; cs is ignored. Max one access per 2 cycles.
//   - Latency: accept edge -> ready in the next cycle.
// - Staging and commit:
//   - Committed outputs change only on the commit edge, then hold stable for the whole tick
//     cycle and until the next commit.
//   - A write accepted in the commit cycle is included in that commit.
//   - Multiple writes to one register between commits: last value wins.
// - Gate stretch:
//   - Staged-gate 0->1 written sets gate_pend[v].
//   - Commit: env_gate[v] <= staged_gate[v] | gate_pend[v]; gate_pend[v] <= 0, unless a
//     0->1 write lands in that same cycle, in which case set wins.
//   - A 1-then-0 write pair within one tick gives env_gate=1 for one tick, then 0.
//   - A 0-then-1-then-0 sequence likewise yields one high tick.
// - Writes to voices >= NUM_VOICES are ignored. ENV3 reads 0 if NUM_VOICES<3.
// STRUCTURE
// - sid_pkg: NUM_VOICES_MAX=3; address constants REG_CTRL_OFS=4, REG_AD_OFS=5,
//   REG_SR_OFS=6, REG_ENV3=5'h1C; typedef struct packed {atk,dcy,stn,rls,gate} env_cfg_t;
//   bus-state enum.
// - Sub-module sid_tick_gen (divider: commit strobe + env_clk_en). All else inline.
// TESTING
// - Reset, CLK_DIV=32: all outputs 0; env_clk_en first high in cycle 32, then every 32
//   cycles, single-cycle.
// - Write AD(v0)=0x9A at cnt=5: env_atk[0]=9, env_dcy[0]=A appear at commit edge (cnt 30),
//   not before; stable during tick.
// - Write SR(v1)=0x35 in the commit cycle: env_stn[1]=3, env_rls[1]=5 on that commit.
//   A write one cycle later appears at the next commit.
// - CTRL(v2)=1 then CTRL(v2)=0 within one tick: env_gate[2]=1 for exactly one tick period,
//   then 0.
// - env_vol[2]=0x7F, read 0x1C: ready one cycle after accept, rdata=0x7F.
//   Read 0x05: rdata=0. cs held high gives accepts every 2nd cycle.
// - n_reset low mid-access and mid-interval: ready, gate_pend, env_* cleared.
//   Divider restarts and first tick is again CLK_DIV cycles after release.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared types and register-map constants for the SID envelope front end.
// Holds the voice config bundle, bus FSM states and address helpers.
package sid_pkg;

  localparam int NUM_VOICES_MAX = 3;

  localparam int REG_CTRL_OFS = 4;
  localparam int REG_AD_OFS   = 5;
  localparam int REG_SR_OFS   = 6;

  localparam logic [4:0] REG_ENV3 = 5'h1C;

  typedef struct packed {
    logic [3:0] atk;
    logic [3:0] dcy;
    logic [3:0] stn;
    logic [3:0] rls;
    logic       gate;
  } env_cfg_t;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_t;

  function automatic logic [4:0] reg_addr(
    input int v,
    input int ofs
  );
    return 5'(7 * v + ofs);
  endfunction

endpackage

// File: rtl/sid_tick_gen.sv
// Envelope tick divider: o_commit is high in the cycle before o_tick.
// Ports: clk, n_reset (sync, active low), o_commit, o_tick.
module sid_tick_gen #(
  parameter int CLK_DIV = 32
) (
  input  logic clk,
  input  logic n_reset,
  output logic o_commit,
  output logic o_tick
);

  localparam logic [15:0] CNT_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] CNT_CMT  = 16'(CLK_DIV - 2);

  logic [15:0] r_cnt;
  logic        r_tick;

  assign o_commit = (r_cnt == CNT_CMT);
  assign o_tick   = r_tick;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 16'd1;
      r_tick <= o_commit;
    end
  end

endmodule

// File: rtl/sid_env_ctrl.sv
// SID envelope register front end: bus decode, staging, tick-aligned commit.
// Ports: clk, n_reset, cs/we/addr/wdata/rdata/ready bus, env_* outputs, env_vol in.
module sid_env_ctrl
  import sid_pkg::*;
#(
  parameter int CLK_DIV    = 32,
  parameter int NUM_VOICES = 3
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      cs,
  input  logic                      we,
  input  logic [4:0]                addr,
  input  logic [7:0]                wdata,
  output logic [7:0]                rdata,
  output logic                      ready,
  output logic                      env_clk_en,
  output logic [NUM_VOICES*4-1:0]   env_atk,
  output logic [NUM_VOICES*4-1:0]   env_dcy,
  output logic [NUM_VOICES*4-1:0]   env_stn,
  output logic [NUM_VOICES*4-1:0]   env_rls,
  output logic [NUM_VOICES-1:0]     env_gate,
  input  logic [NUM_VOICES*8-1:0]   env_vol
);

  bus_state_t r_state;
  bus_state_t w_state_nxt;

  env_cfg_t [NUM_VOICES-1:0] r_stg;
  env_cfg_t [NUM_VOICES-1:0] r_cmt;
  env_cfg_t [NUM_VOICES-1:0] w_stg_nxt;
  env_cfg_t [NUM_VOICES-1:0] w_cmt_nxt;

  logic [NUM_VOICES-1:0] r_pend;
  logic [NUM_VOICES-1:0] w_set;

  logic [7:0] r_rdata;
  logic [7:0] w_rd_val;
  logic [7:0] w_env3;
  logic       w_acc;
  logic       w_wr;
  logic       w_commit;
  logic       w_tick;
  logic       w_unused_vol;

  sid_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk      (clk),
    .n_reset  (n_reset),
    .o_commit (w_commit),
    .o_tick   (w_tick)
  );

  assign env_clk_en   = w_tick;
  assign rdata        = r_rdata;
  assign w_unused_vol = ^env_vol;

  if (NUM_VOICES >= 3) begin : g_env3
    assign w_env3 = env_vol[23:16];
  end else begin : g_no_env3
    assign w_env3 = '0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc       = 1'b0;
    ready       = 1'b0;
    unique case (r_state)
      BUS_IDLE: begin
        if (cs) begin
          w_acc       = 1'b1;
          w_state_nxt = BUS_RESP;
        end
      end
      BUS_RESP: begin
        ready       = 1'b1;
        w_state_nxt = BUS_IDLE;
      end
      default: w_state_nxt = BUS_IDLE;
    endcase
  end

  assign w_wr     = w_acc & we;
  assign w_rd_val = (!we && addr == REG_ENV3) ? w_env3 : 8'h00;

  // Staged next-state feeds the commit directly so a write landing
  // in the commit cycle is part of that commit.
  always_comb begin
    w_stg_nxt = r_stg;
    w_set     = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (w_wr) begin
        unique case (1'b1)
          (addr == reg_addr(v, REG_CTRL_OFS)): begin
            w_stg_nxt[v].gate = wdata[0];
            w_set[v]          = wdata[0] & ~r_stg[v].gate;
          end
          (addr == reg_addr(v, REG_AD_OFS)): begin
            w_stg_nxt[v].atk = wdata[7:4];
            w_stg_nxt[v].dcy = wdata[3:0];
          end
          (addr == reg_addr(v, REG_SR_OFS)): begin
            w_stg_nxt[v].stn = wdata[7:4];
            w_stg_nxt[v].rls = wdata[3:0];
          end
          default: ;
        endcase
      end
    end
  end

  // A gate rise since the last commit is held for one tick even if
  // the staged gate has already dropped again.
  always_comb begin
    w_cmt_nxt = w_stg_nxt;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_cmt_nxt[v].gate = w_stg_nxt[v].gate | r_pend[v] | w_set[v];
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= BUS_IDLE;
      r_rdata <= '0;
      r_stg   <= '0;
      r_cmt   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stg   <= w_stg_nxt;
      if (w_acc) r_rdata <= w_rd_val;
      if (w_commit) begin
        r_cmt  <= w_cmt_nxt;
        r_pend <= w_set;
      end else begin
        r_pend <= r_pend | w_set;
      end
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign env_atk[4*v +: 4] = r_cmt[v].atk;
    assign env_dcy[4*v +: 4] = r_cmt[v].dcy;
    assign env_stn[4*v +: 4] = r_cmt[v].stn;
    assign env_rls[4*v +: 4] = r_cmt[v].rls;
    assign env_gate[v]       = r_cmt[v].gate;
  end

endmodule

// File: tb/tb_sid_env_ctrl.sv
// Scoreboard bench for sid_env_ctrl: bus responses and per-tick env outputs.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_sid_env_ctrl;

  logic        clk;
  logic        n_reset;
  logic        cs;
  logic        we;
  logic [4:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready;
  logic        env_clk_en;
  logic [11:0] env_atk;
  logic [11:0] env_dcy;
  logic [11:0] env_stn;
  logic [11:0] env_rls;
  logic [2:0]  env_gate;
  logic [23:0] env_vol;

  sid_env_ctrl #(
    .CLK_DIV    (32),
    .NUM_VOICES (3)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .cs         (cs),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .env_clk_en (env_clk_en),
    .env_atk    (env_atk),
    .env_dcy    (env_dcy),
    .env_stn    (env_stn),
    .env_rls    (env_rls),
    .env_gate   (env_gate),
    .env_vol    (env_vol)
  );

  typedef struct {
    int         cyc;
    bit         chk;
    logic [7:0] d;
  } rd_t;

  rd_t         rd_q[$];
  logic [50:0] env_q[$];

  int checks = 0;
  int errors = 0;
  int gcyc   = 0;
  int tb_cnt = 0;
  bit in_rst = 1'b1;
  logic [50:0] hold = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    gcyc   = gcyc + 1;
    in_rst = !n_reset;
    if (!n_reset) tb_cnt = 0;
    else tb_cnt = (tb_cnt == 31) ? 0 : tb_cnt + 1;
  end

  always @(negedge clk) begin : monitor
    logic [50:0] act;
    logic [50:0] e;
    rd_t         r;
    act = {env_atk, env_dcy, env_stn, env_rls, env_gate};
    if (in_rst) begin
      hold = '0;
      checks++;
      if (act !== '0 || ready !== 1'b0 || env_clk_en !== 1'b0 || rdata !== 8'h00) begin
        errors++;
        $display("FAIL reset_state env=%h rdy=%b tick=%b rdata=%h want all 0",
                 act, ready, env_clk_en, rdata);
      end
    end else begin
      checks++;
      if (env_clk_en !== (tb_cnt == 31)) begin
        errors++;
        $display("FAIL tick_timing cnt=%0d en=%b want %b", tb_cnt, env_clk_en, tb_cnt == 31);
      end
      if (env_clk_en === 1'b1) begin
        checks++;
        if (env_q.size() == 0) begin
          errors++;
          $display("FAIL tick_unexpected env=%h no expectation queued", act);
        end else begin
          e = env_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL tick_value got=%h want=%h", act, e);
          end
          hold = e;
        end
      end else begin
        checks++;
        if (act !== hold) begin
          errors++;
          $display("FAIL env_hold cnt=%0d got=%h want=%h", tb_cnt, act, hold);
        end
      end
      if (ready === 1'b1) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL ready_unexpected cyc=%0d", gcyc);
        end else begin
          r = rd_q.pop_front();
          if (gcyc != r.cyc) begin
            errors++;
            $display("FAIL ready_latency cyc=%0d want %0d", gcyc, r.cyc);
          end
          if (r.chk) begin
            checks++;
            if (rdata !== r.d) begin
              errors++;
              $display("FAIL rdata got=%h want=%h", rdata, r.d);
            end
          end
        end
      end
    end
  end

  task automatic go_cnt(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_cnt != k && n < 64);
    if (tb_cnt != k) begin
      errors++;
      $display("FAIL go_cnt reached=%0d want=%0d", tb_cnt, k);
    end
  endtask

  task automatic push_env(
    input logic [11:0] a,
    input logic [11:0] d,
    input logic [11:0] s,
    input logic [11:0] r,
    input logic [2:0]  g
  );
    env_q.push_back({a, d, s, r, g});
  endtask

  task automatic bus(
    input logic       w,
    input logic [4:0] a,
    input logic [7:0] d,
    input bit         chk,
    input logic [7:0] exp_d
  );
    rd_t it;
    cs    = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    it.cyc = gcyc + 1;
    it.chk = chk;
    it.d   = exp_d;
    rd_q.push_back(it);
    @(negedge clk);
    cs = 1'b0;
    we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rd_t it;
    n_reset = 1'b0;
    cs      = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    env_vol = {8'h7F, 8'h22, 8'h11};
    repeat (3) @(negedge clk);
    n_reset = 1'b1;

    go_cnt(5);
    bus(1'b1, 5'h05, 8'h9A, 1'b0, 8'h00);
    push_env(12'h009, 12'h00A, 12'h000, 12'h000, 3'b000);
    go_cnt(31);

    go_cnt(30);
    push_env(12'h009, 12'h00A, 12'h030, 12'h050, 3'b000);
    bus(1'b1, 5'h0D, 8'h35, 1'b0, 8'h00);

    push_env(12'h009, 12'h00A, 12'h030, 12'h050, 3'b000);
    go_cnt(31);
    push_env(12'h009, 12'h00A, 12'h040, 12'h060, 3'b100);
    bus(1'b1, 5'h0D, 8'h46, 1'b0, 8'h00);

    go_cnt(3);
    bus(1'b1, 5'h12, 8'h01, 1'b0, 8'h00);
    go_cnt(10);
    bus(1'b1, 5'h12, 8'h00, 1'b0, 8'h00);
    go_cnt(31);

    push_env(12'hC09, 12'h30A, 12'h040, 12'h060, 3'b000);
    go_cnt(2);
    bus(1'b1, 5'h13, 8'hC3, 1'b0, 8'h00);
    bus(1'b1, 5'h1A, 8'hFF, 1'b0, 8'h00);
    bus(1'b1, 5'h00, 8'h55, 1'b0, 8'h00);
    bus(1'b0, 5'h1C, 8'h00, 1'b1, 8'h7F);
    bus(1'b0, 5'h05, 8'h00, 1'b1, 8'h00);
    env_vol[23:16] = 8'h81;
    cs   = 1'b1;
    we   = 1'b0;
    addr = 5'h1C;
    for (int i = 0; i < 3; i++) begin
      it.cyc = gcyc + 1 + 2 * i;
      it.chk = 1'b1;
      it.d   = 8'h81;
      rd_q.push_back(it);
    end
    repeat (6) @(negedge clk);
    cs = 1'b0;
    go_cnt(31);

    go_cnt(3);
    bus(1'b1, 5'h04, 8'h01, 1'b0, 8'h00);
    bus(1'b1, 5'h04, 8'h00, 1'b0, 8'h00);
    bus(1'b1, 5'h05, 8'h77, 1'b0, 8'h00);
    go_cnt(12);
    cs      = 1'b1;
    we      = 1'b0;
    addr    = 5'h1C;
    n_reset = 1'b0;
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;

    push_env(12'h000, 12'h000, 12'h000, 12'h000, 3'b000);
    go_cnt(31);
    push_env(12'h000, 12'h000, 12'h000, 12'h000, 3'b000);
    go_cnt(31);
    repeat (2) @(negedge clk);

    checks++;
    if (env_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained env_q=%0d rd_q=%0d want 0 0",
               env_q.size(), rd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
